lcd_spi_rx: RTL and testbench

Receive-side counterpart of the ST7789 4-line serial LCD driver: samples the SCK/CS/DC/SDA lines the driver emits, rebuilds bytes tagged command/parameter, and buffers them in a FIFO readable over CSR. An optional decoder tracks CASET/RASET/RAMWR and emits addressed RGB565 pixel writes. It serves as an on-chip loopback checker and bus monitor for the LCD path.

---
 rtl/lcd_spi_pkg.sv | 23 ++
 rtl/lcd_spi_rx_if.sv | 40 ++++
 rtl/lcd_spi_byte_rx.sv | 82 ++++++++
 rtl/lcd_spi_rx.sv | 173 +++++++++++++++++
 tb/tb_lcd_spi_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_spi_pkg.sv
// Shared opcodes, decoder state encoding and the power-on drawing window for the LCD SPI receiver.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lcd_spi_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Default window covers the full 135x240 panel.
    localparam logic [8:0] DEF_XS = 9'd0;
    localparam logic [8:0] DEF_XE = 9'd134;
    localparam logic [8:0] DEF_YS = 9'd0;
    localparam logic [8:0] DEF_YE = 9'd239;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_CASET,
        DEC_RASET,
        DEC_RAMWR
    } dec_state_t;

endpackage

// File: rtl/lcd_spi_rx_if.sv
// Bundle of the receiver's SPI pins, byte read port, error flags and pixel strobe.
// Latency: n/a (wiring only).
// Backpressure: rx_valid/rx_ready on the byte port; the pixel port has none.
// Ports: spi_* raw pins in; rx_* show-ahead byte FIFO head; ovf/frag sticky flags cleared by err_clr;
//        pix_* one-cycle addressed RGB565 write. master = receiver, slave = consumer.
interface lcd_spi_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          spi_sck;
    logic          spi_cs_n;
    logic          spi_dc;
    logic          spi_sda;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_dc;
    logic [7:0]    rx_byte;
    logic [CW-1:0] rx_count;
    logic          err_clr;
    logic          ovf;
    logic          frag;
    logic          pix_valid;
    logic [8:0]    pix_x;
    logic [8:0]    pix_y;
    logic [15:0]   pix_rgb;

    modport master (
        input  spi_sck, spi_cs_n, spi_dc, spi_sda, rx_ready, err_clr,
        output rx_valid, rx_dc, rx_byte, rx_count, ovf, frag,
        output pix_valid, pix_x, pix_y, pix_rgb
    );

    modport slave (
        output spi_sck, spi_cs_n, spi_dc, spi_sda, rx_ready, err_clr,
        input  rx_valid, rx_dc, rx_byte, rx_count, ovf, frag,
        input  pix_valid, pix_x, pix_y, pix_rgb
    );

endinterface

// File: rtl/lcd_spi_byte_rx.sv
// Synchronises the SPI pins, detects SCK rising edges and assembles MSB-first bytes tagged with DC.
// Latency: byte_vld pulses SYNC_STAGES+2 clk after the 8th SCK rising edge reaches the pins.
// Backpressure: none; the strobe is a single-cycle pulse that downstream must take or drop.
// Ports: clk/rst; spi_* async pins; byte_vld/byte_dc/byte_dat assembled byte; frag_pulse on a partial byte.
module lcd_spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_dc,
    input  logic       spi_sda,
    output logic       byte_vld,
    output logic       byte_dc,
    output logic [7:0] byte_dat,
    output logic       frag_pulse
);
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, dc_sync, sda_sync;
    logic       sck_s, cs_s, dc_s, sda_s;
    logic       sck_d, sck_rise;
    logic       armed;
    logic       done;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    // CS chain resets low so that a CS held low across reset never looks like a fresh
    // high->low frame start; reception only arms after CS is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            cs_sync  <= '0;
            dc_sync  <= '0;
            sda_sync <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            dc_sync  <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], spi_sda};
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_d      <= 1'b0;
            armed      <= 1'b0;
            done       <= 1'b0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            byte_vld   <= 1'b0;
            byte_dc    <= 1'b0;
            byte_dat   <= 8'd0;
            frag_pulse <= 1'b0;
        end else begin
            sck_d      <= sck_s;
            done       <= 1'b0;
            byte_vld   <= done;
            frag_pulse <= 1'b0;
            if (cs_s) begin
                // Deselect discards any partial byte; bit_cnt clears so this pulses once.
                armed      <= 1'b1;
                bit_cnt    <= 3'd0;
                frag_pulse <= (bit_cnt != 3'd0);
            end else if (armed && sck_rise) begin
                shreg   <= {shreg[6:0], sda_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    done     <= 1'b1;
                    byte_dat <= {shreg[6:0], sda_s};
                    byte_dc  <= dc_s;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_spi_rx.sv
// ST7789 4-line SPI receiver: byte FIFO with sticky ovf/frag flags, optional CASET/RASET/RAMWR pixel decoder.
// Latency: rx_valid rises SYNC_STAGES+3 clk after the 8th SCK edge; pix_valid registers on the same edge as the push.
// Backpressure: rx_ready pops the show-ahead head; a push into a full FIFO without a pop is dropped and sets ovf.
// Ports: clk, rst (sync, active-high), bus (lcd_spi_rx_if.master).
// Build option: define LCD_RX_PIXEL_DECODE_EN to include the decoder; otherwise pix_* are tied to 0.
module lcd_spi_rx
    import lcd_spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    lcd_spi_rx_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic          byte_vld, byte_dc, frag_pulse;
    logic [7:0]    byte_dat;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push_ok, drop;

    lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (bus.spi_sck),
        .spi_cs_n   (bus.spi_cs_n),
        .spi_dc     (bus.spi_dc),
        .spi_sda    (bus.spi_sda),
        .byte_vld   (byte_vld),
        .byte_dc    (byte_dc),
        .byte_dat   (byte_dat),
        .frag_pulse (frag_pulse)
    );

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = bus.rx_valid & bus.rx_ready;
    assign push_ok = byte_vld & (~full | pop);
    assign drop    = byte_vld & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {byte_dc, byte_dat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bus.ovf  <= 1'b0;
            bus.frag <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            // New errors take priority over a concurrent clear.
            bus.ovf  <= drop       | (bus.ovf  & ~bus.err_clr);
            bus.frag <= frag_pulse | (bus.frag & ~bus.err_clr);
        end
    end

    assign bus.rx_valid = (count != '0);
    assign bus.rx_count = count;
    assign bus.rx_dc    = bus.rx_valid & mem[rd_ptr][8];
    assign bus.rx_byte  = bus.rx_valid ? mem[rd_ptr][7:0] : 8'd0;

`ifdef LCD_RX_PIXEL_DECODE_EN
    dec_state_t  state, state_n;
    logic [8:0]  xs, xe, ys, ye, x, y, xs_n, xe_n, ys_n, ye_n, x_n, y_n;
    logic [2:0]  pidx, pidx_n;
    logic [23:0] pbuf, pbuf_n;
    logic [7:0]  hi, hi_n;
    logic        have_hi, have_hi_n;
    logic        pv, pv_n;
    logic [8:0]  px, py, px_n, py_n;
    logic [15:0] prgb, prgb_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DEC_IDLE;
            xs <= DEF_XS; xe <= DEF_XE; ys <= DEF_YS; ye <= DEF_YE;
            x <= 9'd0; y <= 9'd0; pidx <= 3'd0; pbuf <= 24'd0;
            hi <= 8'd0; have_hi <= 1'b0;
            pv <= 1'b0; px <= 9'd0; py <= 9'd0; prgb <= 16'd0;
        end else begin
            state <= state_n;
            xs <= xs_n; xe <= xe_n; ys <= ys_n; ye <= ye_n;
            x <= x_n; y <= y_n; pidx <= pidx_n; pbuf <= pbuf_n;
            hi <= hi_n; have_hi <= have_hi_n;
            pv <= pv_n; px <= px_n; py <= py_n; prgb <= prgb_n;
        end
    end

    // Decodes every pushed byte, including ones the FIFO drops, so the pixel stream
    // does not depend on the consumer keeping up.
    always_comb begin
        state_n = state;
        xs_n = xs; xe_n = xe; ys_n = ys; ye_n = ye;
        x_n = x; y_n = y; pidx_n = pidx; pbuf_n = pbuf;
        hi_n = hi; have_hi_n = have_hi;
        pv_n = 1'b0; px_n = px; py_n = py; prgb_n = prgb;
        if (byte_vld) begin
            if (!byte_dc) begin
                pidx_n    = 3'd0;
                have_hi_n = 1'b0;
                case (byte_dat)
                    CMD_CASET: state_n = DEC_CASET;
                    CMD_RASET: state_n = DEC_RASET;
                    CMD_RAMWR: begin
                        state_n = DEC_RAMWR;
                        x_n     = xs;
                        y_n     = ys;
                    end
                    default:   state_n = DEC_IDLE;
                endcase
            end else begin
                case (state)
                    DEC_CASET, DEC_RASET: begin
                        // pidx saturates at 4 so trailing parameters are ignored.
                        if (pidx != 3'd4) begin
                            pidx_n = pidx + 3'd1;
                            pbuf_n = {pbuf[15:0], byte_dat};
                            if (pidx == 3'd3) begin
                                if (state == DEC_CASET) begin
                                    xs_n = {pbuf[16], pbuf[15:8]};
                                    xe_n = {pbuf[0], byte_dat};
                                end else begin
                                    ys_n = {pbuf[16], pbuf[15:8]};
                                    ye_n = {pbuf[0], byte_dat};
                                end
                            end
                        end
                    end
                    DEC_RAMWR: begin
                        if (!have_hi) begin
                            hi_n      = byte_dat;
                            have_hi_n = 1'b1;
                        end else begin
                            have_hi_n = 1'b0;
                            pv_n      = 1'b1;
                            px_n      = x;
                            py_n      = y;
                            prgb_n    = {hi, byte_dat};
                            if (x == xe) begin
                                x_n = xs;
                                y_n = (y == ye) ? ys : y + 9'd1;
                            end else begin
                                x_n = x + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pix_valid = pv;
    assign bus.pix_x     = px;
    assign bus.pix_y     = py;
    assign bus.pix_rgb   = prgb;
`else
    assign bus.pix_valid = 1'b0;
    assign bus.pix_x     = 9'd0;
    assign bus.pix_y     = 9'd0;
    assign bus.pix_rgb   = 16'd0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: byte path latency, overflow, full push+pop, frag, pixel decode, abort, reset.
// Latency: SPI driven at clk/4; inputs change 1 time unit after a rising clk edge, outputs sampled there too.
// Backpressure: rx_ready is driven per scenario (held off to fill, pulsed to pop, held on to drain).
module tb_lcd_spi_rx;
    import lcd_spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_spi_rx_if #(.FIFO_DEPTH(16)) bus();

    lcd_spi_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [33:0] pixq[$];
    always @(posedge clk) begin
        #1;
        if (bus.pix_valid === 1'b1) pixq.push_back({bus.pix_x, bus.pix_y, bus.pix_rgb});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        tick(2);
    endtask

    task automatic cs_high();
        bus.spi_sck = 1'b0;
        tick(2);
        bus.spi_cs_n = 1'b1;
        tick(8);
    endtask

    // Returns 2 clk after the last SCK rising edge was placed on the pin.
    task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            bus.spi_sck = 1'b0;
            bus.spi_dc  = dc;
            bus.spi_sda = b[i];
            tick(2);
            bus.spi_sck = 1'b1;
            tick(2);
        end
    endtask

    task automatic spi_byte(input logic dc, input logic [7:0] b);
        spi_bits(dc, b, 8);
    endtask

    task automatic pop_one();
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0b exp=0", bus.rx_valid); end
        checks++; if (bus.rx_count !== 5'd0) begin failures++; $display("FAIL reset_rx_count got=%0d exp=0", bus.rx_count); end
        checks++; if ({bus.rx_dc, bus.rx_byte} !== 9'd0) begin failures++; $display("FAIL reset_head got=%0h exp=0", {bus.rx_dc, bus.rx_byte}); end
        checks++; if ({bus.ovf, bus.frag} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%0b exp=00", {bus.ovf, bus.frag}); end
        checks++; if ({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb} !== 35'd0) begin failures++; $display("FAIL reset_pix got=%0h exp=0", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb}); end
    endtask

    task automatic test_single_byte();
        cs_low();
        spi_byte(1'b0, 8'h11);
        tick(2);
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL lat_early got=%0b exp=0", bus.rx_valid); end
        tick(1);
        checks++; if (bus.rx_valid !== 1'b1) begin failures++; $display("FAIL lat_on_time got=%0b exp=1", bus.rx_valid); end
        cs_high();
        checks++; if (bus.rx_count !== 5'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.rx_count); end
        checks++; if ({bus.rx_dc, bus.rx_byte} !== 9'h011) begin failures++; $display("FAIL single_head got=%0h exp=011", {bus.rx_dc, bus.rx_byte}); end
        pop_one();
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%0b exp=0", bus.rx_valid); end
    endtask

    task automatic test_overflow();
        cs_low();
        for (int i = 0; i < 18; i++) spi_byte(1'b1, 8'(i));
        cs_high();
        checks++; if (bus.rx_count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", bus.rx_count); end
        checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", bus.ovf); end
        for (int i = 0; i < 16; i++) begin
            checks++; if ({bus.rx_dc, bus.rx_byte} !== {1'b1, 8'(i)}) begin failures++; $display("FAIL ovf_entry%0d got=%0h exp=%0h", i, {bus.rx_dc, bus.rx_byte}, {1'b1, 8'(i)}); end
            pop_one();
        end
        checks++; if (bus.rx_count !== 5'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", bus.rx_count); end
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", bus.ovf); end
    endtask

    // Push and pop land on the same edge while full: accepted, no overflow.
    task automatic test_full_push_pop();
        cs_low();
        for (int i = 0; i < 16; i++) spi_byte(1'b1, 8'h40 + 8'(i));
        tick(4);
        checks++; if (bus.rx_count !== 5'd16) begin failures++; $display("FAIL fpp_full got=%0d exp=16", bus.rx_count); end
        spi_byte(1'b1, 8'h50);
        tick(2);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        checks++; if (bus.rx_count !== 5'd16) begin failures++; $display("FAIL fpp_count got=%0d exp=16", bus.rx_count); end
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%0b exp=0", bus.ovf); end
        cs_high();
        for (int i = 0; i < 16; i++) begin
            checks++; if (bus.rx_byte !== 8'h41 + 8'(i)) begin failures++; $display("FAIL fpp_entry%0d got=%0h exp=%0h", i, bus.rx_byte, 8'h41 + 8'(i)); end
            pop_one();
        end
    endtask

    task automatic test_frag();
        cs_low();
        spi_bits(1'b0, 8'hE0, 3);
        cs_high();
        checks++; if (bus.frag !== 1'b1) begin failures++; $display("FAIL frag_set got=%0b exp=1", bus.frag); end
        checks++; if (bus.rx_count !== 5'd0) begin failures++; $display("FAIL frag_nopush got=%0d exp=0", bus.rx_count); end
        cs_low();
        spi_byte(1'b1, 8'hA5);
        cs_high();
        checks++; if (bus.rx_count !== 5'd1) begin failures++; $display("FAIL frag_count got=%0d exp=1", bus.rx_count); end
        checks++; if ({bus.rx_dc, bus.rx_byte} !== 9'h1A5) begin failures++; $display("FAIL frag_head got=%0h exp=1a5", {bus.rx_dc, bus.rx_byte}); end
        pop_one();
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        checks++; if (bus.frag !== 1'b0) begin failures++; $display("FAIL frag_clear got=%0b exp=0", bus.frag); end
    endtask

    task automatic test_pixels();
        logic [8:0]  seq [21] = '{9'h02A, 9'h100, 9'h128, 9'h100, 9'h129,
                                  9'h02B, 9'h100, 9'h135, 9'h100, 9'h136,
                                  9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0,
                                  9'h100, 9'h11F, 9'h1FF, 9'h1FF, 9'h112, 9'h134};
        logic [33:0] exp [5] = '{{9'd40, 9'd53, 16'hF800}, {9'd41, 9'd53, 16'h07E0},
                                 {9'd40, 9'd54, 16'h001F}, {9'd41, 9'd54, 16'hFFFF},
                                 {9'd40, 9'd53, 16'h1234}};
        pixq.delete();
        bus.rx_ready = 1'b1;
        cs_low();
        for (int i = 0; i < 21; i++) spi_byte(seq[i][8], seq[i][7:0]);
        cs_high();
        bus.rx_ready = 1'b0;
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL pix_no_ovf got=%0b exp=0", bus.ovf); end
`ifdef LCD_RX_PIXEL_DECODE_EN
        checks++; if (pixq.size() !== 5) begin failures++; $display("FAIL pix_count got=%0d exp=5", pixq.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= pixq.size() || pixq[i] !== exp[i]) begin
                failures++;
                $display("FAIL pix%0d got=%0h exp=%0h", i, (i < pixq.size()) ? pixq[i] : 34'h0, exp[i]);
            end
        end
`else
        checks++; if (pixq.size() !== 0) begin failures++; $display("FAIL pix_tied_off got=%0d exp=0 (first %0h vs %0h)", pixq.size(), (pixq.size() > 0) ? pixq[0] : 34'h0, exp[0]); end
`endif
    endtask

    task automatic test_abort();
        pixq.delete();
        bus.rx_ready = 1'b1;
        cs_low();
        spi_byte(1'b0, CMD_RAMWR);
        spi_byte(1'b1, 8'h12);
        spi_byte(1'b0, 8'h29);
        spi_byte(1'b1, 8'h34);
        spi_byte(1'b1, 8'h56);
        cs_high();
        bus.rx_ready = 1'b0;
        checks++; if (pixq.size() !== 0) begin failures++; $display("FAIL abort_nopix got=%0d exp=0", pixq.size()); end
    endtask

    task automatic test_reset_mid_ramwr();
        cs_low();
        spi_byte(1'b0, CMD_RAMWR);
        spi_byte(1'b1, 8'h12);
        spi_bits(1'b1, 8'h34, 3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++; if ({bus.rx_valid, bus.rx_count, bus.rx_dc, bus.rx_byte} !== 15'd0) begin failures++; $display("FAIL rmid_fifo got=%0h exp=0", {bus.rx_valid, bus.rx_count, bus.rx_dc, bus.rx_byte}); end
        checks++; if ({bus.ovf, bus.frag} !== 2'b00) begin failures++; $display("FAIL rmid_flags got=%0b exp=00", {bus.ovf, bus.frag}); end
        checks++; if ({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb} !== 35'd0) begin failures++; $display("FAIL rmid_pix got=%0h exp=0", {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb}); end
        // CS never went high after reset, so this byte must be ignored.
        spi_byte(1'b1, 8'h77);
        tick(6);
        checks++; if (bus.rx_count !== 5'd0) begin failures++; $display("FAIL rmid_unarmed got=%0d exp=0", bus.rx_count); end
        cs_high();
        checks++; if (bus.frag !== 1'b0) begin failures++; $display("FAIL rmid_nofrag got=%0b exp=0", bus.frag); end
        pixq.delete();
        bus.rx_ready = 1'b1;
        cs_low();
        spi_byte(1'b0, CMD_CASET);
        spi_byte(1'b1, 8'h00);
        spi_byte(1'b1, 8'h05);
        spi_byte(1'b1, 8'h00);
        spi_byte(1'b1, 8'h07);
        spi_byte(1'b0, CMD_RAMWR);
        spi_byte(1'b1, 8'hAB);
        spi_byte(1'b1, 8'hCD);
        cs_high();
        bus.rx_ready = 1'b0;
`ifdef LCD_RX_PIXEL_DECODE_EN
        checks++; if (pixq.size() !== 1) begin failures++; $display("FAIL rmid_pixcnt got=%0d exp=1", pixq.size()); end
        checks++; if (pixq.size() < 1 || pixq[0] !== {9'd5, 9'd0, 16'hABCD}) begin failures++; $display("FAIL rmid_pix0 got=%0h exp=%0h", (pixq.size() > 0) ? pixq[0] : 34'h0, {9'd5, 9'd0, 16'hABCD}); end
`else
        checks++; if (pixq.size() !== 0) begin failures++; $display("FAIL rmid_tied_off got=%0d exp=0", pixq.size()); end
`endif
        checks++; if (bus.rx_count !== 5'd0) begin failures++; $display("FAIL rmid_drained got=%0d exp=0", bus.rx_count); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_dc   = 1'b0;
        bus.spi_sda  = 1'b0;
        bus.rx_ready = 1'b0;
        bus.err_clr  = 1'b0;
        test_reset();
        tick(4);
        test_single_byte();
        test_overflow();
        test_full_push_pop();
        test_frag();
        test_pixels();
        test_abort();
        test_reset_mid_ramwr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
